// File: rtl/rv_pkg.sv
// Shared integer-register constants for the write-back / register-file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: REG_W, REG_ADDR_W, NUM_REGS and ZERO_REG, the hardwired-zero index.
package rv_pkg;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// Bundle between the pipeline and the write-back register file.
// Latency: n/a (wiring only).
// Backpressure: stall_i holds the WB stage, and flush_i drops the EX result.
// master: pipeline side. It drives the EX result, the stall/flush controls and the read requests.
// slave:  register file. It returns read data, the staged entry and the commit pulse.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = rv_pkg::REG_W,
  parameter int unsigned ADDR_W = rv_pkg::REG_ADDR_W
);
  logic [ADDR_W-1:0] waddr_i;
  logic              we_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_i;
  logic              flush_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic              wb_valid_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic              commit_o;

  modport master (
    output waddr_i, we_i, wdata_i, stall_i, flush_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, wb_valid_o, wb_addr_o, commit_o
  );

  modport slave (
    input  waddr_i, we_i, wdata_i, stall_i, flush_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, wb_valid_o, wb_addr_o, commit_o
  );
endinterface

// File: rtl/regfile_array.sv
// NUM_REGS x DATA_W storage. It has one synchronous write port and two asynchronous read ports.
// Latency: a write is visible on the reads after the edge; reads are combinational.
// Backpressure: none. The write happens whenever we is high.
// Ports: clk, rst (synchronous clear of every entry), we/waddr/wdata, raddr1/rdata1, raddr2/rdata2.
module regfile_array #(
  parameter int unsigned DATA_W   = rv_pkg::REG_W,
  parameter int unsigned ADDR_W   = rv_pkg::REG_ADDR_W,
  parameter int unsigned NUM_REGS = rv_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage. A one-entry staging register feeds the 32x32 integer register file.
// Latency: an EX result is committed at the first unstalled edge after capture (2 edges minimum).
// Backpressure: stall_i freezes the stage and blocks commit; flush_i drops the EX result presented this cycle.
// Ports: clk, rst (synchronous, active-high), bus (wb_regfile_if.slave): EX write, stall/flush,
//        two combinational read ports, and the staged entry export (wb_valid_o/wb_addr_o).
// Build option: WB_RF_BYPASS_EN. When it is defined, reads forward the staged entry. When it is
//        undefined, reads see the array only.
module wb_regfile
  import rv_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_REGS = rv_pkg::NUM_REGS
) (
  input  logic        clk,
  input  logic        rst,
  wb_regfile_if.slave bus
);
  logic              stg_valid;
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_data;
  logic              commit_q;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata1;
  logic [DATA_W-1:0] arr_rdata2;

  // Stall wins over flush. Nothing is captured while stalled, so flush has nothing to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
      commit_q  <= 1'b0;
    end else if (bus.stall_i) begin
      commit_q  <= 1'b0;
    end else begin
      commit_q  <= stg_valid;
      stg_valid <= bus.we_i & ~bus.flush_i & (bus.waddr_i != ZERO_REG);
      stg_addr  <= bus.waddr_i;
      stg_data  <= bus.wdata_i;
    end
  end

  // The rst term keeps a pending entry from committing at the resetting edge.
  assign arr_we = ~rst & ~bus.stall_i & stg_valid;

  regfile_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (arr_we),
    .waddr  (stg_addr),
    .wdata  (stg_data),
    .raddr1 (bus.raddr1_i),
    .rdata1 (arr_rdata1),
    .raddr2 (bus.raddr2_i),
    .rdata2 (arr_rdata2)
  );

  always_comb begin
    bus.rdata1_o = arr_rdata1;
    bus.rdata2_o = arr_rdata2;
`ifdef WB_RF_BYPASS_EN
    // A staged entry is newer than the array contents.
    if (stg_valid && stg_addr == bus.raddr1_i) bus.rdata1_o = stg_data;
    if (stg_valid && stg_addr == bus.raddr2_i) bus.rdata2_o = stg_data;
`endif
    if (!bus.re1_i || bus.raddr1_i == ZERO_REG) bus.rdata1_o = '0;
    if (!bus.re2_i || bus.raddr2_i == ZERO_REG) bus.rdata2_o = '0;
  end

  assign bus.wb_valid_o = stg_valid;
  assign bus.wb_addr_o  = stg_addr;
  assign bus.commit_o   = commit_q;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Receiving end of the EX write-back interface (waddr, we, wdata), the write-back stage plus the integer register file.
- A one-entry WB staging register captures each EX result, then commits it into a 32x32 register array.
- Two combinational read ports serve ID, with optional forwarding of the pending staged write.
- Also exports the staged entry so hazard logic can see it.

Parameters:
- DATA_W, 32, register width (matches RegBus).
- ADDR_W, 5, register index width (matches RegAddrBus).
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- waddr_i  in  ADDR_W  EX destination register.
- we_i  in  1  EX write enable.
- wdata_i  in  DATA_W  EX result.
- stall_i  in  1  hold WB stage; no capture, no commit.
- flush_i  in  1  discard the EX result presented this cycle.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  ADDR_W  read port 1 address.
- rdata1_o  out  DATA_W  read port 1 data, combinational.
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  ADDR_W  read port 2 address.
- rdata2_o  out  DATA_W  read port 2 data, combinational.
- wb_valid_o  out  1  staged write pending.
- wb_addr_o  out  ADDR_W  staged destination.
- commit_o  out  1  registered one-cycle pulse: the array was written at the last edge.

Behaviour:
- Reset (rst=1 at an edge):
  - All array entries are set to 0.
  - stg_valid, wb_valid_o and commit_o are set to 0; wb_addr_o is set to 0.
  - A pending staged write is discarded, never committed.
- Staging, evaluated at every rising edge with rst=0:
  - stall_i=1: the staged entry holds, nothing is committed, EX input is ignored, commit_o goes to 0.
  - stall_i=0: if stg_valid, the array is written at stg_addr with stg_data and commit_o goes to 1; otherwise commit_o goes to 0.
  - stall_i=0, same edge: stg_valid <= we_i & ~flush_i & (waddr_i != 0). stg_addr and stg_data load waddr_i and wdata_i.
  - Result: an EX result presented at edge N is committed at the first unstalled edge after N; minimum latency is 2 edges.
- stall_i and flush_i both high: stall wins, since nothing is captured anyway.
- A write to x0 never creates a staged entry, never commits, and never raises commit_o.
- Reads, purely combinational:
  - re=0 or raddr=0 -> 0.
  - Else if stg_valid and stg_addr==raddr -> stg_data (forwarding, see macro).
  - Else -> array[raddr].
  - Both ports may read the same address in the same cycle.
- Back-to-back writes to the same register: the older value is in the array, the newer in staging; the read returns the newer one.
- No state machine beyond stg_valid (EMPTY/FULL). FULL->FULL on every unstalled cycle with a valid capture.
- wb_valid_o = stg_valid; wb_addr_o = stg_addr.

Optional Feature:
- Macro: WB_RF_BYPASS_EN.
- Defined: reads forward the staged entry as described above.
- Undefined: reads return the array value only; a read of the staged register returns the stale value. The hazard unit stalls on the exported wb_valid_o/wb_addr_o instead.
- Timing and commit behaviour are identical in both builds.

Decomposition:
- Shared package rv_pkg holds: REG_W=32, REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0.
- One sub-module, regfile_array: NUM_REGS x DATA_W storage with one synchronous write port, two asynchronous read ports and synchronous clear on rst.
- Staging, forwarding and x0 masking stay in wb_regfile.

Test Plan:
- Reset, then read x1..x31 on both ports -> all 0; wb_valid_o=0; commit_o=0.
- we=1, waddr=5, wdata=32'hDEADBEEF at edge 0, no stall -> wb_valid_o=1 after edge 0; commit_o=1 after edge 1; raddr1=5 returns DEADBEEF from edge 0 on (bypass) or from edge 1 on (bypass off).
- Write x7=1 then x7=2 on consecutive edges -> after the second edge rdata=2 (bypass on); array holds 2 after the third edge.
- stall_i=1 for 3 cycles with x3=32'h55 staged -> commit_o stays 0, wb_valid_o stays 1, EX inputs are ignored; first unstalled edge commits 55.
- we=1, waddr=0, wdata=32'hFFFF_FFFF -> no staging, no commit, x0 reads 0. flush_i=1 with we=1, waddr=9 -> x9 unchanged.
- x4=32'hA staged, then rst=1 for one edge -> x4 reads 0 and commit_o never pulses.
